// File: rtl/counter_seek_arbiter.sv
// counter_seek_arbiter: round-robin arbiter and seek sequencer for a shared
// 2-bit up/down position counter. It grants one of two clients and steps the
// counter to the client's target by the shortest path, at one step every
// STEP_DIV cycles. It also keeps a shadow of the counter position and pulses
// done to the owner when the counter arrives.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   i_req      level requests, bit i from client i; held until o_done[i]
//   i_tgt0     client 0 target position, sampled at grant
//   i_tgt1     client 1 target position, sampled at grant
//   o_step     counter step enable (decode of registered state)
//   o_up_down  counter direction: 0 = increment, 1 = decrement
//   o_pos      shadow counter position
//   o_busy     high while a transaction is in MOVE or DONE
//   o_gnt      one-hot owner of the current transaction, 0 when idle
//   o_done     one-cycle completion pulse to the owner
module counter_seek_arbiter #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_tgt0,
  input  logic [1:0] i_tgt1,
  output logic       o_step,
  output logic       o_up_down,
  output logic [1:0] o_pos,
  output logic       o_busy,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done
);

  localparam int unsigned      DIV_W    = 8;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [1:0]       r_pos,     w_pos_nxt;
  logic [1:0]       r_tgt,     w_tgt_nxt;
  logic             r_up_down, w_up_down_nxt;
  logic [1:0]       r_gnt,     w_gnt_nxt;
  logic [1:0]       r_done,    w_done_nxt;
  logic             r_busy,    w_busy_nxt;
  logic [DIV_W-1:0] r_div,     w_div_nxt;
  logic             r_last,    w_last_nxt;

  logic             w_step;
  logic             w_win;
  logic [1:0]       w_tgt_sel;
  logic [1:0]       w_dist;
  logic [1:0]       w_pos_step;

  // Winner: a lone requester wins; on a tie the client that did not win last.
  assign w_win      = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_tgt_sel  = w_win ? i_tgt1 : i_tgt0;
  // Forward distance mod 4; only a distance of 3 is shorter going down.
  assign w_dist     = w_tgt_sel - r_pos;
  assign w_pos_step = r_up_down ? (r_pos - 2'd1) : (r_pos + 2'd1);

  // Step decodes registered state only, so reset drops it immediately.
  assign w_step     = (r_state == S_MOVE) && (r_div == '0);

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pos     <= 2'd0;
      r_tgt     <= 2'd0;
      r_up_down <= 1'b0;
      r_gnt     <= 2'd0;
      r_done    <= 2'd0;
      r_busy    <= 1'b0;
      r_div     <= '0;
      r_last    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_tgt     <= w_tgt_nxt;
      r_up_down <= w_up_down_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_div     <= w_div_nxt;
      r_last    <= w_last_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_tgt_nxt     = r_tgt;
    w_up_down_nxt = r_up_down;
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = 2'd0;
    w_busy_nxt    = r_busy;
    w_div_nxt     = r_div;
    w_last_nxt    = r_last;

    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_last_nxt    = w_win;
          w_gnt_nxt     = {w_win, ~w_win};
          w_tgt_nxt     = w_tgt_sel;
          w_busy_nxt    = 1'b1;
          w_up_down_nxt = (w_dist == 2'd3);
          w_div_nxt     = DIV_LOAD;
          if (w_dist == 2'd0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = {w_win, ~w_win};
          end else begin
            w_state_nxt = S_MOVE;
          end
        end
      end

      S_MOVE: begin
        if (w_step) begin
          // Shadow tracks the counter, which moves on this same edge.
          w_pos_nxt = w_pos_step;
          w_div_nxt = DIV_LOAD;
          if (w_pos_step == r_tgt) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = r_gnt;
          end
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'd0;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_step    = w_step;
  assign o_up_down = r_up_down;
  assign o_pos     = r_pos;
  assign o_busy    = r_busy;
  assign o_gnt     = r_gnt;
  assign o_done    = r_done;

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Directed bench for counter_seek_arbiter with STEP_DIV=4. A separate
// position counter driven only by step/up_down is compared against the
// shadow position every cycle of every transaction.
module tb_counter_seek_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_req;
  logic [1:0] i_tgt0;
  logic [1:0] i_tgt1;
  logic       o_step;
  logic       o_up_down;
  logic [1:0] o_pos;
  logic       o_busy;
  logic [1:0] o_gnt;
  logic [1:0] o_done;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] m_pos;

  counter_seek_arbiter #(.STEP_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_tgt0    (i_tgt0),
    .i_tgt1    (i_tgt1),
    .o_step    (o_step),
    .o_up_down (o_up_down),
    .o_pos     (o_pos),
    .o_busy    (o_busy),
    .o_gnt     (o_gnt),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared counter, reset by the same signal.
  always @(posedge clk or negedge reset) begin
    if (!reset)      m_pos <= 2'd0;
    else if (o_step) m_pos <= o_up_down ? m_pos - 2'd1 : m_pos + 2'd1;
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Present a request at a negedge, let the next edge sample it (cycle 0),
  // then check every cycle of the transaction and the following idle cycle.
  // nsteps is the number of counter steps, p0 the starting position.
  task automatic txn(input logic [1:0] rq, input logic [1:0] t0, input logic [1:0] t1,
                     input logic [1:0] egnt, input logic [1:0] p0,
                     input int nsteps, input logic eud);
    int         last_k;
    int         n;
    logic [1:0] ep;
    i_req  = rq;
    i_tgt0 = t0;
    i_tgt1 = t1;
    @(posedge clk);
    last_k = nsteps * 4 + 1;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      n  = (k - 1) / 4;
      ep = eud ? p0 - 2'(n) : p0 + 2'(n);
      check("gnt",   8'(o_gnt),  8'(egnt));
      check("busy",  8'(o_busy), 8'd1);
      check("step",  8'(o_step), 8'((k % 4) == 0));
      check("done",  8'(o_done), (k == last_k) ? 8'(egnt) : 8'd0);
      check("pos",   8'(o_pos),  8'(ep));
      check("model", 8'(o_pos),  8'(m_pos));
      if (nsteps > 0) check("up_down", 8'(o_up_down), 8'(eud));
      if (k == last_k) i_req = i_req & ~egnt;
    end
    @(negedge clk);
    ep = eud ? p0 - 2'(nsteps) : p0 + 2'(nsteps);
    check("idle_gnt",  8'(o_gnt),  8'd0);
    check("idle_busy", 8'(o_busy), 8'd0);
    check("idle_done", 8'(o_done), 8'd0);
    check("idle_step", 8'(o_step), 8'd0);
    check("idle_pos",  8'(o_pos),  8'(ep));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    i_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    i_req  = 2'b00;
    i_tgt0 = 2'd0;
    i_tgt1 = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_pos",  8'(o_pos),     8'd0);
    check("rst_step", 8'(o_step),    8'd0);
    check("rst_ud",   8'(o_up_down), 8'd0);
    check("rst_busy", 8'(o_busy),    8'd0);
    check("rst_gnt",  8'(o_gnt),     8'd0);
    check("rst_done", 8'(o_done),    8'd0);
    reset = 1'b1;

    // Single requester, d=1 then d=2 upward.
    txn(2'b01, 2'd1, 2'd0, 2'b01, 2'd0, 1, 1'b0);
    txn(2'b01, 2'd3, 2'd0, 2'b01, 2'd1, 2, 1'b0);

    // d=3 goes one step down.
    do_reset();
    txn(2'b10, 2'd0, 2'd3, 2'b10, 2'd0, 1, 1'b1);

    // Ties from reset: client 0 first, client 1 wraps 2->3->0.
    do_reset();
    txn(2'b11, 2'd2, 2'd0, 2'b01, 2'd0, 2, 1'b0);
    txn(2'b10, 2'd2, 2'd0, 2'b10, 2'd2, 2, 1'b0);

    // Repeated ties alternate; target equal to pos completes with no step.
    txn(2'b11, 2'd0, 2'd0, 2'b01, 2'd0, 0, 1'b0);
    txn(2'b10, 2'd0, 2'd0, 2'b10, 2'd0, 0, 1'b0);
    txn(2'b11, 2'd1, 2'd1, 2'b01, 2'd0, 1, 1'b0);
    txn(2'b10, 2'd1, 2'd1, 2'b10, 2'd1, 0, 1'b0);
    i_req = 2'b00;

    // Reset in the middle of a two-step move, while step is high.
    do_reset();
    i_req  = 2'b01;
    i_tgt0 = 2'd2;
    @(posedge clk);
    repeat (8) @(negedge clk);
    check("mid_step", 8'(o_step), 8'd1);
    check("mid_pos",  8'(o_pos),  8'd1);
    reset = 1'b0;
    i_req = 2'b00;
    #1;
    check("arst_step", 8'(o_step),    8'd0);
    check("arst_pos",  8'(o_pos),     8'd0);
    check("arst_gnt",  8'(o_gnt),     8'd0);
    check("arst_busy", 8'(o_busy),    8'd0);
    check("arst_ud",   8'(o_up_down), 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_done", 8'(o_done), 8'd0);
    end
    reset = 1'b1;
    txn(2'b01, 2'd0, 2'd0, 2'b01, 2'd0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
